ahb_lite_wait_ram: RTL
======================

// Module: ahb_lite_wait_ram
// PURPOSE
//  AHB-Lite slave: word-organised RAM with programmable wait states and protocol error responses.
//  Sits downstream of the SDRAM HW-test traffic master as a known-good stand-in for the SDRAM controller.
//  Lets the master and its checking logic be verified in isolation, and lets bus stalls be exercised
//  deterministically. Counts completed reads, writes and errors for debug LEDs.
// PARAMETERS
//  ADDR_BITS    10  RAM depth = 2**ADDR_BITS words; index = HADDR[ADDR_BITS+1:2]; upper bits ignored (alias)
//  WAIT_STATES  2   HREADYOUT-low cycles per OKAY data phase (0..15)
//  CNT_BITS     16  width of debug counters
// PORTS
//  HCLK       in   1   bus clock
//  HRESETn    in   1   asynchronous active-low reset
//  HADDR      in   32  address
//  HBURST     in   3   ignored (single transfers only)
//  HSEL       in   1   slave select
//  HSIZE      in   3   0=byte 1=half 2=word; others illegal
//  HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ
//  HWDATA     in   32  write data (data phase)
//  HWRITE     in   1   1=write
//  HREADY     in   1   bus ready (tie to HREADYOUT in single-slave system)
//  HRDATA     out  32  read data
//  HREADYOUT  out  1   slave ready
//  HRESP      out  1   0=OKAY 1=ERROR
//  WR_CNT     out  CNT_BITS  completed OKAY writes (wraps)
//  RD_CNT     out  CNT_BITS  completed OKAY reads (wraps)
//  ERR_CNT    out  CNT_BITS  ERROR responses (saturates at all-ones)
// BEHAVIOUR
//  Reset (async): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, all counters 0. RAM contents untouched.
//  Accept: HSEL & HTRANS[1] & HREADY at posedge -> latch addr, size, write; start data phase.
//   IDLE/BUSY/unselected transfers: no access, zero-wait OKAY.
//  Legal check at accept: HSIZE<=2 and aligned (half: HADDR[0]=0; word: HADDR[1:0]=0).
//  FSM: IDLE  : HREADYOUT=1; legal accept -> WAIT (WAIT_STATES>0) or LAST; illegal -> ERR1.
//       WAIT  : HREADYOUT=0, HRESP=0; wait counter increments from 1; at WAIT_STATES -> LAST.
//       LAST  : HREADYOUT=1, HRESP=0; transfer completes this edge. Write commits HWDATA here.
//               Read: HRDATA = RAM[latched index]. RD_CNT/WR_CNT +1. A new accept on this edge
//               -> WAIT/LAST/ERR1 (back-to-back); else -> IDLE.
//       ERR1  : HREADYOUT=0, HRESP=1 -> ERR2.
//       ERR2  : HREADYOUT=1, HRESP=1; ERR_CNT +1; no RAM access; new accept allowed as in LAST.
//  HRDATA = 0 outside a read LAST cycle.
//  Byte lanes: byte -> lane HADDR[1:0]; half -> lanes {HADDR[1],0}+1..+0; word -> all lanes.
//   Only enabled lanes written; reads always return the full word.
//  Latency: OKAY transfer = WAIT_STATES+1 data-phase cycles; ERROR = 2 cycles.
//  Write-then-read of the same address back-to-back returns the new data (commit precedes read phase).
//  Reset mid data phase: returns to IDLE immediately; an uncommitted write is dropped, no count change.
//  HWDATA sampled only in LAST; values in WAIT cycles are don't-care.
// TESTING
//  1 WAIT_STATES=2: write 0x12345678 @0x10, read @0x10 -> HREADYOUT low 2 cycles each; HRDATA=0x12345678; WR_CNT=1, RD_CNT=1.
//  2 After 1: byte write @0x13 HWDATA=0xAB000000 -> read @0x10 returns 0xAB345678; half write @0x12 0xCDEF0000 -> 0xCDEF5678.
//  3 HSIZE=3 @0x20, and word @0x22 -> each gives HRESP=1 for 2 cycles, HREADYOUT 0 then 1; RAM unchanged; ERR_CNT=2.
//  4 Traffic-master pattern: 8 writes @k*0x10004 (data=addr), then reads -> all match; WR_CNT=8, RD_CNT=8; repeat with WAIT_STATES=0.
//  5 Assert HRESETn in WAIT of write 0xDEADBEEF @0x40 -> HREADYOUT=1 immediately; later read @0x40 returns old value.
//  6 HSEL=0 with NONSEQ, and HTRANS=BUSY with HSEL=1 -> HREADYOUT stays 1, HRESP=0, no counter change.

Source files
------------

// File: rtl/ahb_lite_wait_ram_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_wait_ram_if
//   AHB-Lite signal bundle between one master and the wait-state RAM slave.
//   Clock and reset are not part of the bundle and stay plain module ports.
//
//   Signals (master -> slave):
//     HADDR[31:0]   address
//     HBURST[2:0]   burst type (the slave ignores it)
//     HSEL          slave select
//     HSIZE[2:0]    transfer size
//     HTRANS[1:0]   IDLE/BUSY/NONSEQ/SEQ
//     HWDATA[31:0]  write data (data phase)
//     HWRITE        1 = write
//     HREADY        bus-level ready
//   Signals (slave -> master):
//     HRDATA[31:0]  read data
//     HREADYOUT     slave ready
//     HRESP         0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
interface ahb_lite_wait_ram_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_wait_ram.sv
// ---------------------------------------------------------------------------
// ahb_lite_wait_ram
//   AHB-Lite slave wrapping a word-organised RAM. Every OKAY transfer takes
//   WAIT_STATES+1 data-phase cycles; illegal transfers (bad size or
//   misaligned) get the standard two-cycle ERROR response. Completed reads,
//   writes and error responses are counted for debug LEDs. Used as a
//   known-good stand-in for the SDRAM controller behind the traffic master.
//
//   Parameters:
//     ADDR_BITS    RAM depth = 2**ADDR_BITS words, index = HADDR[ADDR_BITS+1:2]
//                  (higher address bits alias)
//     WAIT_STATES  HREADYOUT-low cycles per OKAY transfer (0..15)
//     CNT_BITS     width of the debug counters
//
//   Ports:
//     HCLK         bus clock
//     HRESETn      asynchronous active-low reset
//     bus          AHB-Lite slave modport (address/data/handshake signals)
//     WR_CNT       completed OKAY writes (wraps)
//     RD_CNT       completed OKAY reads (wraps)
//     ERR_CNT      ERROR responses (saturates at all-ones)
// ---------------------------------------------------------------------------
module ahb_lite_wait_ram #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2,
    parameter int CNT_BITS    = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_wait_ram_if.slave    bus,
    output logic [CNT_BITS-1:0]   WR_CNT,
    output logic [CNT_BITS-1:0]   RD_CNT,
    output logic [CNT_BITS-1:0]   ERR_CNT
);

    localparam int            DEPTH  = 2 ** ADDR_BITS;
    localparam logic [3:0]    WS     = WAIT_STATES[3:0];

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [3:0]             be_q;
    logic                   wr_q;

    logic                   accept;
    logic                   legal;
    logic [3:0]             be_d;
    logic                   hready_out;
    logic                   hresp;

    logic [31:0]            mem [DEPTH];

    // HBURST and the aliased upper address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{bus.HBURST, bus.HADDR[31:ADDR_BITS+2]};

    // -----------------------------------------------------------------------
    // Address-phase decode
    // -----------------------------------------------------------------------
    // A new transfer can only start while this slave is driving HREADYOUT
    // high (IDLE, LAST, ERR2); in a single-slave system HREADY mirrors it.
    assign accept = bus.HSEL && bus.HTRANS[1] && bus.HREADY &&
                    (state_q == ST_IDLE || state_q == ST_LAST || state_q == ST_ERR2);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        legal = 1'b0;
        be_d  = 4'b0000;
        unique case (bus.HSIZE)
            3'd0: begin
                legal = 1'b1;
                be_d  = 4'b0001 << bus.HADDR[1:0];
            end
            3'd1: begin
                legal = (bus.HADDR[0] == 1'b0);
                be_d  = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal = (bus.HADDR[1:0] == 2'b00);
                be_d  = 4'b1111;
            end
            default: begin
                legal = 1'b0;
                be_d  = 4'b0000;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Data-phase FSM: next state and bus response
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hready_out = 1'b1;
        hresp      = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                hresp = (state_q == ST_ERR2);
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WS != 4'd0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 4'd1;
                    end else begin
                        state_d = ST_LAST;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                hready_out = 1'b0;
                if (wait_cnt_q == WS) begin
                    state_d = ST_LAST;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_ERR1: begin
                // First ERROR cycle holds the bus so the master can cancel
                // its pipelined address phase.
                hready_out = 1'b0;
                hresp      = 1'b1;
                state_d    = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.HREADYOUT = hready_out;
    assign bus.HRESP     = hresp;

    // Read data is combinational from the latched index so that a read
    // issued right behind a write to the same word sees the committed data.
    assign bus.HRDATA = (state_q == ST_LAST && !wr_q) ? mem[idx_q] : 32'h0;

    // -----------------------------------------------------------------------
    // State and transfer-attribute registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            be_q       <= 4'b0000;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                idx_q <= bus.HADDR[ADDR_BITS+1:2];
                be_q  <= be_d;
                wr_q  <= bus.HWRITE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // RAM write port: commits only on the completing (LAST) edge
    // -----------------------------------------------------------------------
    // NOTE: the RAM array has no reset; its contents must survive HRESETn.
    // A reset mid data phase forces state_q to IDLE, which drops the write.
    always_ff @(posedge HCLK) begin
        if (state_q == ST_LAST && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Debug counters
    // -----------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            WR_CNT  <= '0;
            RD_CNT  <= '0;
            ERR_CNT <= '0;
        end else begin
            if (state_q == ST_LAST) begin
                if (wr_q) begin
                    WR_CNT <= WR_CNT + 1'b1;
                end else begin
                    RD_CNT <= RD_CNT + 1'b1;
                end
            end
            if (state_q == ST_ERR2 && ERR_CNT != {CNT_BITS{1'b1}}) begin
                ERR_CNT <= ERR_CNT + 1'b1;
            end
        end
    end

endmodule
